arb_crossbar_rr: RTL and testbench

- Parametrised, registered N x N crossbar. Successor to the fixed 2/3/4-port mux crossbars.
- Each input presents a message, destination index and domain bit under val/rdy handshake.
- Each output has a one-entry output register and its own round-robin arbiter, which resolves contention between inputs targeting the same output.
- Sits between masters and slaves in the on-chip network. Carries the security-domain bit alongside data.

---
 rtl/arb_crossbar_rr.sv | 139 +++++++++++++
 tb/tb_arb_crossbar_rr.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_crossbar_rr.sv
// Registered N x N crossbar: one output register and one round-robin arbiter per output.
// Optional security-domain filter, enabled by defining ARB_CROSSBAR_DOMAIN_FILTER_EN.
module arb_crossbar_rr #(
  parameter int p_nbits  = 32,
  parameter int p_nports = 4,
  parameter int p_dbits  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [p_nports-1:0]           in_val,
  output logic [p_nports-1:0]           in_rdy,
  input  logic [p_nports*p_nbits-1:0]   in_msg,
  input  logic [p_nports*p_dbits-1:0]   in_dest,
  input  logic [p_nports-1:0]           in_domain,
`ifdef ARB_CROSSBAR_DOMAIN_FILTER_EN
  input  logic [p_nports-1:0]           out_port_domain,
  output logic [p_nports-1:0]           viol,
`endif
  output logic [p_nports-1:0]           out_val,
  input  logic [p_nports-1:0]           out_rdy,
  output logic [p_nports*p_nbits-1:0]   out_msg,
  output logic [p_nports-1:0]           out_domain
);

  localparam int p_pbits = $clog2(p_nports);

  logic [p_nports-1:0]         req   [p_nports];
  logic [p_nports-1:0]         gnt   [p_nports];
  logic [p_pbits-1:0]          ptr_q [p_nports];
  logic [p_pbits-1:0]          ptr_d [p_nports];
  logic [p_nports-1:0]         accept;
  logic [p_nports-1:0]         drop;
  logic [p_nports-1:0]         val_q, val_d;
  logic [p_nports-1:0]         dom_q, dom_d;
  logic [p_nports*p_nbits-1:0] msg_q, msg_d;
  logic [p_dbits-1:0]          dest_i;
  logic                        found;
  int                          pos;
`ifdef ARB_CROSSBAR_DOMAIN_FILTER_EN
  logic [p_nports-1:0]         blocked;
  logic [p_nports-1:0]         viol_q;
`endif

  // Destination decode; an out-of-range destination is accepted and discarded.
  always_comb begin
    dest_i = '0;
    drop   = '0;
`ifdef ARB_CROSSBAR_DOMAIN_FILTER_EN
    blocked = '0;
`endif
    for (int o = 0; o < p_nports; o++) req[o] = '0;
    for (int i = 0; i < p_nports; i++) begin
      dest_i = in_dest[i*p_dbits +: p_dbits];
      if (in_val[i] && int'(dest_i) >= p_nports) drop[i] = 1'b1;
      for (int o = 0; o < p_nports; o++) begin
        if (in_val[i] && int'(dest_i) == o) begin
          req[o][i] = 1'b1;
`ifdef ARB_CROSSBAR_DOMAIN_FILTER_EN
          if (in_domain[i] && !out_port_domain[o]) begin
            req[o][i]  = 1'b0;
            blocked[i] = 1'b1;
          end
`endif
        end
      end
    end
  end

  // Round-robin: first requester at or above ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pos   = 0;
    for (int o = 0; o < p_nports; o++) begin
      gnt[o] = '0;
      found  = 1'b0;
      for (int k = 0; k < p_nports; k++) begin
        pos = int'(ptr_q[o]) + k;
        if (pos >= p_nports) pos = pos - p_nports;
        for (int i = 0; i < p_nports; i++) begin
          if (!found && req[o][i] && i == pos) begin
            gnt[o][i] = 1'b1;
            found     = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    accept = '0;
    in_rdy = '0;
    val_d  = val_q;
    dom_d  = dom_q;
    msg_d  = msg_q;
    ptr_d  = ptr_q;
    for (int o = 0; o < p_nports; o++) begin
      accept[o] = !val_q[o] || out_rdy[o];
      if (val_q[o] && out_rdy[o]) val_d[o] = 1'b0;
      for (int i = 0; i < p_nports; i++) begin
        if (gnt[o][i] && accept[o]) begin
          in_rdy[i]                 = 1'b1;
          val_d[o]                  = 1'b1;
          dom_d[o]                  = in_domain[i];
          msg_d[o*p_nbits +: p_nbits] = in_msg[i*p_nbits +: p_nbits];
          ptr_d[o]                  = (i == p_nports-1) ? '0 : p_pbits'(i+1);
        end
      end
    end
    in_rdy = (in_rdy | drop) & {p_nports{reset}};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val_q <= '0;
      dom_q <= '0;
      msg_q <= '0;
      for (int o = 0; o < p_nports; o++) ptr_q[o] <= '0;
    end else begin
      val_q <= val_d;
      dom_q <= dom_d;
      msg_q <= msg_d;
      for (int o = 0; o < p_nports; o++) ptr_q[o] <= ptr_d[o];
    end
  end

`ifdef ARB_CROSSBAR_DOMAIN_FILTER_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) viol_q <= '0;
    else        viol_q <= blocked;
  end

  assign viol = viol_q;
`endif

  assign out_val    = val_q;
  assign out_domain = dom_q;
  assign out_msg    = msg_q;

endmodule

// File: tb/tb_arb_crossbar_rr.sv
// Directed, table-driven bench for arb_crossbar_rr (4-port main instance, 5-port instance for dropped destinations).
// Exercises the ARB_CROSSBAR_DOMAIN_FILTER_EN ports as well when that macro is defined.
`timescale 1ns/1ps
module tb_arb_crossbar_rr;
  localparam int NB = 32;
  localparam int NP = 4;
  localparam int DB = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [NP-1:0]      in_val, in_rdy, in_domain, out_val, out_rdy, out_domain;
  logic [NP*NB-1:0]   in_msg, out_msg;
  logic [NP*DB-1:0]   in_dest;

  logic [4:0]         in_val5, in_rdy5, in_domain5, out_val5, out_rdy5, out_domain5;
  logic [39:0]        in_msg5, out_msg5;
  logic [14:0]        in_dest5;
`ifdef ARB_CROSSBAR_DOMAIN_FILTER_EN
  logic [NP-1:0]      out_port_domain, viol;
  logic [4:0]         out_port_domain5, viol5;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arb_crossbar_rr #(.p_nbits(NB), .p_nports(NP), .p_dbits(DB)) dut (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg), .in_dest(in_dest), .in_domain(in_domain),
`ifdef ARB_CROSSBAR_DOMAIN_FILTER_EN
    .out_port_domain(out_port_domain), .viol(viol),
`endif
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .out_domain(out_domain)
  );

  arb_crossbar_rr #(.p_nbits(8), .p_nports(5), .p_dbits(3)) dut5 (
    .clk(clk), .reset(reset),
    .in_val(in_val5), .in_rdy(in_rdy5), .in_msg(in_msg5), .in_dest(in_dest5), .in_domain(in_domain5),
`ifdef ARB_CROSSBAR_DOMAIN_FILTER_EN
    .out_port_domain(out_port_domain5), .viol(viol5),
`endif
    .out_val(out_val5), .out_rdy(out_rdy5), .out_msg(out_msg5), .out_domain(out_domain5)
  );

  typedef struct {
    logic [3:0]  val;
    logic [7:0]  dest;
    logic [3:0]  dom;
    logic [3:0]  ordy;
    logic [3:0]  e_rdy;
    logic [3:0]  e_oval;
    logic [15:0] e_src;
    logic [3:0]  e_odom;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [31:0] msgOf(int i, int v);
    logic [7:0] a;
    a = 8'(i);
    return {8'hA0 | a, 8'(v), 16'h5A5A};
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(vec_t t, int v);
    @(negedge clk);
    in_val    = t.val;
    in_dest   = t.dest;
    in_domain = t.dom;
    out_rdy   = t.ordy;
    for (int i = 0; i < NP; i++) in_msg[i*NB +: NB] = msgOf(i, v);
    #1;
    checkOutput($sformatf("v%0d in_rdy", v), 32'(in_rdy), 32'(t.e_rdy));
    step();
    checkOutput($sformatf("v%0d out_val", v), 32'(out_val), 32'(t.e_oval));
    checkOutput($sformatf("v%0d out_domain", v), 32'(out_domain), 32'(t.e_odom));
    for (int o = 0; o < NP; o++) begin
      if (t.e_src[o*4 +: 4] != 4'hF)
        checkOutput($sformatf("v%0d out_msg%0d", v, o), out_msg[o*NB +: NB],
                    msgOf(int'(t.e_src[o*4 +: 4]), v));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // val, dest, dom, ordy, e_rdy, e_oval, e_src, e_odom
    vecs[0]  = '{4'b1011, 8'h45, 4'b0010, 4'b1111, 4'b0001, 4'b0010, 16'hFF0F, 4'b0000};
    vecs[1]  = '{4'b1011, 8'h45, 4'b0010, 4'b1111, 4'b0010, 4'b0010, 16'hFF1F, 4'b0010};
    vecs[2]  = '{4'b1011, 8'h45, 4'b0010, 4'b1111, 4'b1000, 4'b0010, 16'hFF3F, 4'b0000};
    vecs[3]  = '{4'b1011, 8'h45, 4'b0010, 4'b1111, 4'b0001, 4'b0010, 16'hFF0F, 4'b0000};
    vecs[4]  = '{4'b1011, 8'h45, 4'b0010, 4'b1111, 4'b0010, 4'b0010, 16'hFF1F, 4'b0010};
    vecs[5]  = '{4'b1011, 8'h45, 4'b0010, 4'b1111, 4'b1000, 4'b0010, 16'hFF3F, 4'b0000};
    vecs[6]  = '{4'b0000, 8'h00, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 16'hFFFF, 4'b0000};
    vecs[7]  = '{4'b1111, 8'h1B, 4'b1010, 4'b1111, 4'b1111, 4'b1111, 16'h0123, 4'b0101};
    vecs[8]  = '{4'b1111, 8'hE4, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 16'h3210, 4'b0000};
    vecs[9]  = '{4'b0001, 8'h00, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 16'hFFFF, 4'b0000};
    vecs[10] = '{4'b0000, 8'h00, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 16'hFFFF, 4'b0000};
    vecs[11] = '{4'b1111, 8'h88, 4'b0000, 4'b1111, 4'b1100, 4'b0101, 16'hF3F2, 4'b0000};
    vecs[12] = '{4'b1111, 8'h88, 4'b0000, 4'b1111, 4'b0011, 4'b0101, 16'hF1F0, 4'b0000};
    vecs[13] = '{4'b0000, 8'h00, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 16'hFFFF, 4'b0000};

    reset      = 1'b1;
    in_val     = 4'b0001;
    in_dest    = '0;
    in_domain  = '0;
    in_msg     = '0;
    out_rdy    = '1;
    in_val5    = '0;
    in_dest5   = '0;
    in_domain5 = '0;
    in_msg5    = '0;
    out_rdy5   = '1;
`ifdef ARB_CROSSBAR_DOMAIN_FILTER_EN
    out_port_domain  = '1;
    out_port_domain5 = '1;
`endif

    // Reset state, with a request pending to show in_rdy is held low.
    #2 reset = 1'b0;
    step();
    checkOutput("rst out_val", 32'(out_val), 32'h0);
    checkOutput("rst out_domain", 32'(out_domain), 32'h0);
    checkOutput("rst in_rdy", 32'(in_rdy), 32'h0);
    for (int o = 0; o < NP; o++)
      checkOutput($sformatf("rst out_msg%0d", o), out_msg[o*NB +: NB], 32'h0);
    @(negedge clk);
    reset  = 1'b1;
    in_val = '0;

    // First transfer: in0 -> out2, one-cycle latency.
    @(negedge clk);
    in_val            = 4'b0001;
    in_dest           = 8'h02;
    in_msg[0 +: NB]   = 32'hA5A5A5A5;
    #1;
    checkOutput("first in_rdy", 32'(in_rdy), 32'h1);
    checkOutput("first out_val before edge", 32'(out_val), 32'h0);
    step();
    checkOutput("first out_val", 32'(out_val), 32'h4);
    checkOutput("first out_msg2", out_msg[2*NB +: NB], 32'hA5A5A5A5);
    @(negedge clk);
    in_val = '0;
    step();
    checkOutput("drain out_val", 32'(out_val), 32'h0);
    checkOutput("drain out_msg2 held", out_msg[2*NB +: NB], 32'hA5A5A5A5);

    for (int v = 0; v < 14; v++) applyStimulus(vecs[v], v);

    // Backpressure on out0 for five cycles, then pass-through without a bubble.
    @(negedge clk);
    in_val             = 4'b0100;
    in_dest            = '0;
    in_domain          = '0;
    in_msg[2*NB +: NB] = 32'h22220001;
    out_rdy            = 4'b1110;
    #1;
    checkOutput("bp fill in_rdy", 32'(in_rdy), 32'h4);
    step();
    checkOutput("bp fill out_val", 32'(out_val), 32'h1);
    checkOutput("bp fill out_msg0", out_msg[0 +: NB], 32'h22220001);
    in_msg[2*NB +: NB] = 32'h22220002;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("bp%0d in_rdy", c), 32'(in_rdy), 32'h0);
      step();
      checkOutput($sformatf("bp%0d out_val", c), 32'(out_val), 32'h1);
      checkOutput($sformatf("bp%0d out_msg0", c), out_msg[0 +: NB], 32'h22220001);
    end
    @(negedge clk);
    out_rdy = '1;
    #1;
    checkOutput("bp release in_rdy", 32'(in_rdy), 32'h4);
    step();
    checkOutput("bp release out_val", 32'(out_val), 32'h1);
    checkOutput("bp release out_msg0", out_msg[0 +: NB], 32'h22220002);
    @(negedge clk);
    in_msg[2*NB +: NB] = 32'h22220003;
    #1;
    checkOutput("bp stream in_rdy", 32'(in_rdy), 32'h4);
    step();
    checkOutput("bp stream out_msg0", out_msg[0 +: NB], 32'h22220003);
    @(negedge clk);
    in_val = '0;
    step();
    checkOutput("bp drain out_val", 32'(out_val), 32'h0);

    // Asynchronous reset with out1 and out3 full; ptr[0] was 3 beforehand.
    @(negedge clk);
    in_val          = 4'b0011;
    in_dest         = 8'h0D;
    in_msg[0 +: NB] = 32'h0000_0111;
    in_msg[NB +: NB] = 32'h0000_0333;
    out_rdy         = '0;
    step();
    checkOutput("pre-rst out_val", 32'(out_val), 32'hA);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("async rst out_val", 32'(out_val), 32'h0);
    checkOutput("async rst out_msg1", out_msg[NB +: NB], 32'h0);
    checkOutput("async rst out_msg3", out_msg[3*NB +: NB], 32'h0);
    step();
    checkOutput("in rst out_val", 32'(out_val), 32'h0);
    @(negedge clk);
    reset   = 1'b1;
    in_val  = '0;
    out_rdy = '1;
    step();
    checkOutput("post-rst no replay", 32'(out_val), 32'h0);
    @(negedge clk);
    in_val            = 4'b1010;
    in_dest           = '0;
    in_msg[NB +: NB]  = 32'hBEEF0001;
    in_msg[3*NB +: NB] = 32'hBEEF0003;
    #1;
    checkOutput("post-rst ptr0 grant", 32'(in_rdy), 32'h2);
    step();
    checkOutput("post-rst out_val", 32'(out_val), 32'h1);
    checkOutput("post-rst out_msg0", out_msg[0 +: NB], 32'hBEEF0001);
    @(negedge clk);
    in_val = '0;
    step();

    // Five-port instance: destinations 5 and 7 are dropped, 4 is delivered.
    @(negedge clk);
    in_val5    = 5'b00111;
    in_dest5   = 15'b000_000_111_100_101;
    in_msg5    = {8'h00, 8'h00, 8'h33, 8'h22, 8'h11};
    in_domain5 = 5'b00010;
    #1;
    checkOutput("p5 in_rdy", 32'(in_rdy5), 32'h07);
    step();
    checkOutput("p5 out_val", 32'(out_val5), 32'h10);
    checkOutput("p5 out_msg4", 32'(out_msg5[39:32]), 32'h22);
    checkOutput("p5 out_domain", 32'(out_domain5), 32'h10);
    @(negedge clk);
    in_val5 = '0;
    step();
    checkOutput("p5 drain out_val", 32'(out_val5), 32'h0);

`ifdef ARB_CROSSBAR_DOMAIN_FILTER_EN
    // H-domain input aimed at an L-domain output is blocked and flagged.
    @(negedge clk);
    in_val          = 4'b0010;
    in_domain       = 4'b0010;
    in_dest         = '0;
    out_port_domain = 4'b1110;
    #1;
    checkOutput("filt blocked in_rdy", 32'(in_rdy), 32'h0);
    step();
    checkOutput("filt viol", 32'(viol), 32'h2);
    checkOutput("filt out_val", 32'(out_val), 32'h0);
    @(negedge clk);
    out_port_domain = '1;
    #1;
    checkOutput("filt allowed in_rdy", 32'(in_rdy), 32'h2);
    step();
    checkOutput("filt viol clear", 32'(viol), 32'h0);
    checkOutput("filt out_val", 32'(out_val), 32'h1);
    checkOutput("filt out_domain", 32'(out_domain), 32'h1);
    checkOutput("filt viol5", 32'(viol5), 32'h0);
    @(negedge clk);
    in_val = '0;
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
